// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encoding is fixed so software and benches can decode the state port.
package pll_reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // Width of the retry counter; bounds MAX_RETRY to 1..15.
    localparam int RETRY_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals.
// Flops clear asynchronously on rst_n low.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, releases sys_rst_n.
// Define PLL_RESET_CTRL_LOSS_CNT_EN to add the loss_cnt lock-loss counter output.
module pll_reset_ctrl
    import pll_reset_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       error,
    output logic [2:0] state
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               sys_rst_n_q;
    logic               lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d    (locked),
        .q    (lock_s)
    );

    // Retry count holds at its maximum instead of wrapping.
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

    // Next-state, counter and retry decisions for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as lock.
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_RESET;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, retry and registered downstream reset.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            // Release one cycle into RUN; drop on the edge that leaves it.
            sys_rst_n_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
        end
    end

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    assign loss_evt = (state_q == ST_RUN) && !lock_s;

    // Saturating count of lock losses that dropped RUN back to RESET.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_cnt = loss_q;
`endif

    assign pll_rst   = (state_q == ST_RESET);
    assign error     = (state_q == ST_FAIL);
    assign sys_rst_n = sys_rst_n_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl with a cycle reference model.
// Build with PLL_RESET_CTRL_LOSS_CNT_EN to also check loss_cnt.
module tb_pll_reset_ctrl;

    localparam int RST  = 8;
    localparam int STAB = 16;
    localparam int TO   = 100;
    localparam int MAXR = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       error;
    logic [2:0] state;
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
    int         m_loss;
`endif

    int checks  = 0;
    int passes  = 0;
    int edge_no = 0;
    int pulses  = 0;
    logic pr_prev = 1'b1;

    int   m_ph;
    int   m_t;
    int   m_retry;
    logic m_srn;
    logic m_s1;
    logic m_s2;

    pll_reset_ctrl #(
        .RST_CYCLES  (RST),
        .LOCK_STABLE (STAB),
        .LOCK_TIMEOUT(TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .error    (error),
        .state    (state)
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
        ,
        .loss_cnt (loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_ph    = P_RST;
        m_t     = 0;
        m_retry = 0;
        m_srn   = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
        m_loss  = 0;
`endif
    endtask

    // Phase model: m_t is the number of edges spent so far in a phase.
    task automatic m_edge(input logic lk);
        logic ls;
        int   prev;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        prev = m_ph;
        case (m_ph)
            P_RST: begin
                m_t++;
                if (m_t == RST) begin
                    m_ph = P_WAIT;
                    m_t  = 0;
                end
            end
            P_WAIT: begin
                if (ls) begin
                    m_ph = P_STAB;
                    m_t  = 0;
                end else begin
                    m_t++;
                    if (m_t == TO) begin
                        m_retry++;
                        m_t  = 0;
                        m_ph = (m_retry == MAXR) ? P_FAIL : P_RST;
                    end
                end
            end
            P_STAB: begin
                if (!ls) begin
                    m_ph = P_WAIT;
                    m_t  = 0;
                end else begin
                    m_t++;
                    if (m_t == STAB) begin
                        m_ph    = P_RUN;
                        m_retry = 0;
                    end
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m_ph = P_RST;
                    m_t  = 0;
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
                    if (m_loss < 255) m_loss++;
`endif
                end
            end
            default: ;
        endcase
        m_srn = (prev == P_RUN) && (m_ph == P_RUN);
    endtask

    task automatic chk_all();
        chk("state", 32'(state), 32'(m_ph));
        chk("pll_rst", 32'(pll_rst), 32'(m_ph == P_RST));
        chk("sys_rst_n", 32'(sys_rst_n), 32'(m_srn));
        chk("error", 32'(error), 32'(m_ph == P_FAIL));
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
        chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            if (rst_n) m_edge(locked);
            edge_no++;
            @(negedge refclk);
            if (pll_rst && !pr_prev) pulses++;
            pr_prev = pll_rst;
            chk_all();
        end
    endtask

    // Assert rst_n mid-cycle, check async reset values, then release.
    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all();
        cyc(2);
        rst_n   = 1'b0;
        #1;
        rst_n   = 1'b1;
        edge_no = 0;
        pulses  = 1;
        pr_prev = 1'b1;
    endtask

    initial begin
        int r;
        int f;

        m_reset();
        locked = 1'b0;

        // Nominal: lock sampled at edge 20, release 19 edges later.
        do_reset();
        cyc(20);
        locked = 1'b1;
        cyc(19);
        chk("nom_pre", 32'(sys_rst_n), 32'd0);
        cyc(1);
        chk("nom_release", 32'(sys_rst_n), 32'd1);
        chk("nom_error", 32'(error), 32'd0);

        // Lock loss in RUN: 5 low cycles.
        cyc($urandom_range(5, 30));
        locked = 1'b0;
        cyc(2);
        chk("loss_hold", 32'(sys_rst_n), 32'd1);
        cyc(1);
        chk("loss_drop", 32'(sys_rst_n), 32'd0);
        chk("loss_state", 32'(state), 32'(P_RST));
        cyc(2);
        locked = 1'b1;
        cyc(40);
        chk("loss_rerun", 32'(sys_rst_n), 32'd1);
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
        chk("loss_cnt1", 32'(loss_cnt), 32'd1);
`endif

        // Glitchy lock at a random start.
        do_reset();
        locked = 1'b0;
        r = $urandom_range(6, 60);
        cyc(r);
        locked = 1'b1;
        cyc(10);
        locked = 1'b0;
        cyc(1);
        locked = 1'b1;
        f = edge_no;
        cyc(19);
        chk("glitch_pre", 32'(sys_rst_n), 32'd0);
        cyc(1);
        chk("glitch_release", 32'(sys_rst_n), 32'd1);
        chk("glitch_edge", 32'(edge_no), 32'(f + 20));

        // Reset in the middle of STABLE.
        do_reset();
        cyc(12);
        chk("mid_stable", 32'(state), 32'(P_STAB));
        do_reset();

        // Lock exactly on the last timeout cycle of the first attempt.
        locked = 1'b0;
        cyc(TO + RST - 3);
        locked = 1'b1;
        cyc(3);
        chk("to_edge_state", 32'(state), 32'(P_STAB));
        cyc(5);
        locked = 1'b0;
        pulses = 0;
        cyc(400);
        chk("to_edge_pulses", 32'(pulses), 32'd2);
        chk("to_edge_fail", 32'(state), 32'(P_FAIL));

        // No lock: three attempts then terminal FAIL.
        do_reset();
        cyc(400);
        chk("nolock_pulses", 32'(pulses), 32'(MAXR));
        chk("nolock_state", 32'(state), 32'(P_FAIL));
        chk("nolock_error", 32'(error), 32'd1);
        chk("nolock_pll_rst", 32'(pll_rst), 32'd0);

        // Reset out of FAIL, then random lock activity.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            locked = ~locked;
            if (locked) cyc($urandom_range(3, 60));
            else cyc($urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
